// File: rtl/divider_inv_man_if.sv
// Operand/result bundle for the divider inverse (multiply-add) pipeline.
// The master drives quotient/divisor/remainder; the slave returns the dividend.
interface divider_inv_man_if #(
    parameter int N = 8,
    parameter int M = 5
);
    logic             data_rdy;
    logic [N-1:0]     merchant;
    logic [M-1:0]     divisor;
    logic [M-1:0]     remainder;
    logic             res_rdy;
    logic [N+M-1:0]   dividend;
    logic             rem_err;

    modport master (
        output data_rdy, merchant, divisor, remainder,
        input  res_rdy, dividend, rem_err
    );

    modport slave (
        input  data_rdy, merchant, divisor, remainder,
        output res_rdy, dividend, rem_err
    );
endinterface

// File: rtl/divider_inv_man.sv
// Shift-add pipeline rebuilding dividend = merchant * divisor + remainder.
// One stage per divisor bit; flags pairs that a correct divider cannot produce.
module divider_inv_man #(
    parameter int N = 8,
    parameter int M = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    divider_inv_man_if.slave      bus
);
    localparam int W = N + M;

    logic [M-1:0] vld_q, vld_d;
    logic [M-1:0] err_q, err_d;
    logic [W-1:0] acc_q [M];
    logic [W-1:0] acc_d [M];
    logic [N-1:0] mer_q [M];
    logic [N-1:0] mer_d [M];
    logic [M-1:0] div_q [M];
    logic [M-1:0] div_d [M];

    always_comb begin
        vld_d = '0;
        err_d = err_q;
        for (int i = 0; i < M; i++) begin
            acc_d[i] = acc_q[i];
            mer_d[i] = mer_q[i];
            div_d[i] = div_q[i];
        end

        vld_d[0] = bus.data_rdy;
        if (bus.data_rdy) begin
            acc_d[0] = W'(bus.remainder)
                     + (bus.divisor[0] ? W'(bus.merchant) : '0);
            err_d[0] = (bus.divisor == '0)
                     | (bus.remainder >= bus.divisor);
            mer_d[0] = bus.merchant;
            div_d[0] = bus.divisor;
        end

        // Stage i adds merchant << i when divisor bit i is set.
        for (int i = 1; i < M; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                acc_d[i] = acc_q[i-1]
                         + (div_q[i-1][i] ? (W'(mer_q[i-1]) << i) : '0);
                err_d[i] = err_q[i-1];
                mer_d[i] = mer_q[i-1];
                div_d[i] = div_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < M; i++) begin
                acc_q[i] <= '0;
                mer_q[i] <= '0;
                div_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            for (int i = 0; i < M; i++) begin
                acc_q[i] <= acc_d[i];
                mer_q[i] <= mer_d[i];
                div_q[i] <= div_d[i];
            end
        end
    end

    assign bus.res_rdy  = vld_q[M-1];
    assign bus.dividend = acc_q[M-1];
    assign bus.rem_err  = err_q[M-1];
endmodule
